// File: rtl/hilo_pkg.sv
// Shared types and helpers for the HI/LO divide sequencer.
package hilo_pkg;

   localparam int unsigned DIV_LATENCY_DEFAULT = 33;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;

   function automatic word_t neg_if(input word_t v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Restores the signs of the divider's unsigned quotient/remainder for DIV.
module div_sign_fix
   import hilo_pkg::*;
(
   input  word_t q_mag,
   input  word_t r_mag,
   input  logic  is_signed,
   input  logic  a_neg,
   input  logic  b_neg,
   output word_t hi_fix,
   output word_t lo_fix
);

   // Remainder follows the dividend's sign; quotient is negative when signs differ.
   always_comb begin
      lo_fix = neg_if(q_mag, is_signed & (a_neg ^ b_neg));
      hi_fix = neg_if(r_mag, is_signed & a_neg);
   end

endmodule

// File: rtl/hilo_ctrl.sv
// Divide sequencer and architectural HI/LO registers.
module hilo_ctrl
   import hilo_pkg::*;
#(
   parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        div_start,
   input  logic        div_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        div_ctrl,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   input  logic [31:0] div_hi,
   input  logic [31:0] div_lo,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   localparam int unsigned CW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV_LATENCY - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sgn_q, sgn_d;
   logic          a_neg_q, a_neg_d;
   logic          b_neg_q, b_neg_d;
   word_t         div_a_q, div_a_d;
   word_t         div_b_q, div_b_d;
   word_t         hi_q, hi_d;
   word_t         lo_q, lo_d;
   logic          done_q, done_d;
   logic          zero_q, zero_d;
   word_t         hi_fix, lo_fix;

   div_sign_fix u_fix (
      .q_mag     (div_lo),
      .r_mag     (div_hi),
      .is_signed (sgn_q),
      .a_neg     (a_neg_q),
      .b_neg     (b_neg_q),
      .hi_fix    (hi_fix),
      .lo_fix    (lo_fix)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sgn_d   = sgn_q;
      a_neg_d = a_neg_q;
      b_neg_d = b_neg_q;
      div_a_d = div_a_q;
      div_b_d = div_b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      zero_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A start request always takes priority over mthi/mtlo.
            if (div_start) begin
               if (divisor == '0) begin
                  done_d = 1'b1;
                  zero_d = 1'b1;
               end else begin
                  sgn_d   = div_signed;
                  a_neg_d = dividend[31];
                  b_neg_d = divisor[31];
                  div_a_d = neg_if(dividend, div_signed & dividend[31]);
                  div_b_d = neg_if(divisor, div_signed & divisor[31]);
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end else begin
               if (mthi) hi_d = wdata;
               if (mtlo) lo_d = wdata;
            end
         end
         RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_d = FIX;
         end
         FIX: begin
            hi_d    = hi_fix;
            lo_d    = lo_fix;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sgn_q   <= 1'b0;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
         div_a_q <= '0;
         div_b_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sgn_q   <= sgn_d;
         a_neg_q <= a_neg_d;
         b_neg_q <= b_neg_d;
         div_a_q <= div_a_d;
         div_b_q <= div_b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         zero_q  <= zero_d;
      end
   end

   assign div_ctrl = (state_q == RUN);
   assign busy     = (state_q != IDLE);
   assign div_a    = div_a_q;
   assign div_b    = div_b_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign done     = done_q;
   assign div_zero = zero_q;

endmodule
